// File: rtl/serial_alu.sv
// Digit-serial ALU: SLICE bits per beat, LSB first, ripple carry held in a register between beats.
// Latency: operation accepted at edge t, out_valid rises after edge t+N (N = WIDTH/SLICE).
// Backpressure: in_ready only in IDLE; result and flags held in DONE until out_ready, then IDLE.
`timescale 1ns/1ps
module serial_alu #(
    parameter int WIDTH = 32,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carryout,
    output logic             overflow,
    output logic             zero
);

    localparam int N  = WIDTH / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0]    LAST = CW'(N - 1);
    localparam logic [SLICE-1:0] ONES = '1;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_SLT  = 3'd3;
    localparam logic [2:0] OP_AND  = 3'd4;
    localparam logic [2:0] OP_NAND = 3'd5;
    localparam logic [2:0] OP_NOR  = 3'd6;
    localparam logic [2:0] OP_OR   = 3'd7;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carryout_q, carryout_d;
    logic             overflow_q, overflow_d;
    logic             zero_q, zero_d;
    logic             out_valid_q, out_valid_d;

    logic             is_sub;
    logic             is_arith;
    logic [31:0]      shamt;
    logic [SLICE-1:0] a_sl;
    logic [SLICE-1:0] b_sl;
    logic [SLICE-1:0] b_eff;
    logic [SLICE:0]   sum_ext;
    logic [SLICE-1:0] sum_sl;
    logic             slice_cout;
    logic             slice_ovf;
    logic [SLICE-1:0] slice_res;
    logic [WIDTH-1:0] merged;
    logic [WIDTH-1:0] final_res;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign carryout  = carryout_q;
    assign overflow  = overflow_q;
    assign zero      = zero_q;

    // One beat of the datapath: pick slice cnt_q, add/subtract or apply the logic op, merge into result.
    always_comb begin
        is_sub     = (op_q == OP_SUB) || (op_q == OP_SLT);
        is_arith   = (op_q == OP_ADD) || (op_q == OP_SUB);
        shamt      = 32'(cnt_q) * 32'(SLICE);
        a_sl       = SLICE'(a_q >> shamt);
        b_sl       = SLICE'(b_q >> shamt);
        b_eff      = is_sub ? ~b_sl : b_sl;
        sum_ext    = {1'b0, a_sl} + {1'b0, b_eff} + {{SLICE{1'b0}}, carry_q};
        sum_sl     = sum_ext[SLICE-1:0];
        slice_cout = sum_ext[SLICE];
        // Signed overflow: operands share a sign that the sum does not (equals carry-in XOR carry-out of MSB).
        slice_ovf  = (a_sl[SLICE-1] == b_eff[SLICE-1]) && (sum_sl[SLICE-1] != a_sl[SLICE-1]);
        case (op_q)
            OP_ADD, OP_SUB: slice_res = sum_sl;
            OP_XOR:         slice_res = a_sl ^ b_sl;
            OP_AND:         slice_res = a_sl & b_sl;
            OP_NAND:        slice_res = ~(a_sl & b_sl);
            OP_NOR:         slice_res = ~(a_sl | b_sl);
            OP_OR:          slice_res = a_sl | b_sl;
            default:        slice_res = '0;   // SLT fills the result only on the last beat
        endcase
        merged    = (result_q & ~(WIDTH'(ONES) << shamt)) | (WIDTH'(slice_res) << shamt);
        final_res = (op_q == OP_SLT) ? WIDTH'(sum_sl[SLICE-1] ^ slice_ovf) : merged;
    end

    // Next-state and next-register values for IDLE -> RUN (N beats) -> DONE -> IDLE.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        result_d    = result_q;
        carryout_d  = carryout_q;
        overflow_d  = overflow_q;
        zero_d      = zero_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d      = a;
                    b_d      = b;
                    op_d     = op;
                    carry_d  = (op == OP_SUB) || (op == OP_SLT);
                    cnt_d    = '0;
                    result_d = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                carry_d  = slice_cout;
                result_d = merged;
                if (cnt_q == LAST) begin
                    result_d    = final_res;
                    carryout_d  = is_arith ? slice_cout : 1'b0;
                    overflow_d  = is_arith ? slice_ovf : 1'b0;
                    zero_d      = (final_res == '0);
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // All state registers; asynchronous reset aborts any operation in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            result_q    <= '0;
            carryout_q  <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            result_q    <= result_d;
            carryout_q  <= carryout_d;
            overflow_q  <= overflow_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: doc/serial_alu.md
Name: serial_alu

Overview:
- Multi-cycle, digit-serial ALU for the processor datapath.
- Processes SLICE bits per clock, LSB-first, and carries the ripple carry in a register between beats.
- Uses the same 3-bit function encoding as the single-bit ALU slice, generalised to WIDTH bits.
- Adds a valid/ready handshake on both sides and a carry/overflow/zero flag output.

Parameters:
- WIDTH, 32, operand and result width in bits.
- SLICE, 4, bits processed per beat. Must divide WIDTH exactly. N = WIDTH/SLICE beats per operation.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands and op are valid.
- in_ready  output  1  block will accept an operation this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- op  input  3  function: 0 ADD, 1 SUB, 2 XOR, 3 SLT, 4 AND, 5 NAND, 6 NOR, 7 OR.
- out_valid  output  1  result and flags are valid.
- out_ready  input  1  consumer takes the result.
- result  output  WIDTH  operation result.
- carryout  output  1  final carry for ADD/SUB; SUB carry=1 means no borrow.
- overflow  output  1  signed overflow for ADD/SUB.
- zero  output  1  result equals 0.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - State goes to IDLE.
  - result, carryout, overflow, zero, out_valid, beat counter and carry register all clear to 0.
  - in_ready=1, because in_ready is decoded from state==IDLE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: latch a, b, op; load carry register (1 for SUB/SLT, else 0); clear beat counter; go to RUN.
- RUN:
  - in_ready=0.
  - Each edge processes slice k = counter bits [k*SLICE +: SLICE] and writes those result bits.
  - The carry register takes the slice carry-out.
  - SUB/SLT use ~b with carry-in 1.
  - Logic ops ignore the carry path.
  - When counter == N-1, go to DONE after the edge. Otherwise increment the counter.
- DONE:
  - out_valid=1; result and flags held stable.
  - On an edge with out_ready=1, go to IDLE.
  - No accept in the same cycle, so minimum throughput is N+2 cycles per op.
- Latency: accepted at edge t, so out_valid rises after edge t+N.
- Flags:
  - ADD/SUB: carryout = final carry; overflow = carry into MSB XOR carry out of MSB.
  - SLT: computed internally as SUB. result = {WIDTH-1 zeros, sign XOR overflow}; carryout=0, overflow=0.
  - Logic ops: carryout=0, overflow=0.
  - zero is valid in DONE for all ops.
- Inputs a/b/op/in_valid are ignored outside IDLE. Changing them mid-operation has no effect.
- out_ready is ignored outside DONE.
- reset_n asserted mid-RUN or in DONE aborts the operation. No out_valid is produced for the aborted op.
- WIDTH=SLICE (N=1) is legal: one RUN cycle.

Test Plan (WIDTH=32, SLICE=4, N=8 unless stated):
1. ADD a=0xFFFFFFFF, b=0x00000001, accepted at edge t -> out_valid first seen after edge t+8; result=0x00000000, carryout=1, overflow=0, zero=1.
2. SUB a=0x80000000, b=0x00000001 -> result=0x7FFFFFFF, carryout=1, overflow=1, zero=0. SUB a=5, b=5 -> result=0, carryout=1, zero=1.
3. SLT a=0xFFFFFFFF, b=0x00000001 -> result=1. SLT a=0x7FFFFFFF, b=0x80000000 (overflow case) -> result=0, carryout=0, overflow=0, zero=1.
4. a=0xF0F0F0F0, b=0xFF00FF00 with each logic op:
   - XOR -> 0x0FF00FF0
   - AND -> 0xF000F000
   - NAND -> 0x0FFF0FFF
   - NOR -> 0x000F000F
   - OR -> 0xFFF0FFF0
   - Expect carryout=overflow=0 for all.
5. Handshake stress:
   - ADD 3+4 with out_ready=0 for 5 cycles in DONE -> result=7 held stable, in_ready=0 throughout.
   - Driving a new a/b/op during RUN -> ignored.
   - out_ready=1 -> IDLE next edge; back-to-back ops spaced 10 cycles.
6. Reset and parameters:
   - reset_n pulled low at beat 3 of an ADD -> out_valid=0 and result=0 immediately (asynchronous); in_ready=1.
   - After release, a fresh ADD 1+1 -> result=2.
   - Repeat test 1 at WIDTH=8, SLICE=1 -> latency 8, result=0x00, carryout=1.
   - Repeat test 1 at WIDTH=8, SLICE=8 -> latency 1.
